bfloat16_accum_ctrl: RTL and testbench

BFLOAT16_ACCUM_CTRL -- requirements
Module: bfloat16_accum_ctrl

---
 rtl/bfloat16_accum_ctrl.sv | 94 +++++++++
 tb/tb_bfloat16_accum_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bfloat16_accum_ctrl.sv
// bfloat16_accum_ctrl: sequences elements through an external bfloat16 adder into a running sum
module bfloat16_accum_ctrl #(
    parameter int ADD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    input  logic [15:0] add_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [7:0]  out_count
);
    localparam int WW = $clog2(ADD_LAT + 2);

    typedef enum logic [1:0] {IDLE, ACCUM, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   acc_q, acc_d;
    logic [15:0]   add_a_q, add_a_d;
    logic [15:0]   add_b_q, add_b_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          last_q, last_d;
    logic          accept;

    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign accept    = in_valid && in_ready;
    assign out_valid = state_q == DONE;
    assign out_data  = acc_q;
    assign out_count = cnt_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;

    // next-state: first element seeds acc, later ones go through the adder and wait out its latency
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (accept) begin
                acc_d   = in_data;
                cnt_d   = 8'd1;
                state_d = in_last ? DONE : ACCUM;
            end
            ACCUM: if (accept) begin
                add_a_d = acc_q;
                add_b_d = in_data;
                wait_d  = WW'(ADD_LAT);
                last_d  = in_last;
                cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                state_d = WAIT;
            end
            WAIT: if (wait_q != '0) begin
                wait_d = wait_q - 1'b1;
            end else begin
                acc_d   = add_out;
                state_d = last_q ? DONE : ACCUM;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, cleared asynchronously so a partial sum is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            add_a_q <= '0;
            add_b_q <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_bfloat16_accum_ctrl.sv
// tb_bfloat16_accum_ctrl: directed tests with a pipelined bfloat16 adder model attached
module tb_bfloat16_accum_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [15:0] add_a, add_b;
    logic [15:0] add_out = '0;
    logic [15:0] p1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [7:0]  out_count;
    int total = 0;
    int bad = 0;

    bfloat16_accum_ctrl #(.ADD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .add_a(add_a), .add_b(add_b), .add_out(add_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
    );

    always #5 clk = ~clk;

    // positive-normal / zero bfloat16 add, truncating
    function automatic logic [15:0] bf_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y;
        logic [7:0]  d, mb;
        logic [8:0]  s;
        if (a[14:0] == 15'd0) return b;
        if (b[14:0] == 15'd0) return a;
        if (a[14:7] >= b[14:7]) begin x = a; y = b; end else begin x = b; y = a; end
        d  = x[14:7] - y[14:7];
        mb = (d > 8'd8) ? 8'd0 : ({1'b1, y[6:0]} >> d);
        s  = {2'b01, x[6:0]} + {1'b0, mb};
        return s[8] ? {1'b0, x[14:7] + 8'd1, s[7:1]} : {1'b0, x[14:7], s[6:0]};
    endfunction

    // two-stage adder: result valid two edges after add_a/add_b change
    always @(posedge clk) begin
        p1      <= bf_add(add_a, add_b);
        add_out <= p1;
    end

    task automatic send(input logic [15:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL send_ready got=%b exp=1", in_ready); end
        in_valid = 1'b1; in_data = d; in_last = l;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, out_valid, add_a, add_b, out_data, out_count} !== {1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 8'h0}) begin
            bad++;
            $display("FAIL reset_vals got=%b%b %h %h %h %h exp=10 0 0 0 0", in_ready, out_valid, add_a, add_b, out_data, out_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_backpressure();
        send(16'h3F80, 1'b1);
        @(negedge clk);
        total++;
        if ({out_valid, out_data, out_count} !== {1'b1, 16'h3F80, 8'd1}) begin
            bad++; $display("FAIL single got=%b %h %0d exp=1 3f80 1", out_valid, out_data, out_count);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, out_data, out_count} !== {1'b1, 1'b0, 16'h3F80, 8'd1}) begin
                bad++; $display("FAIL backpressure_hold got=%b%b %h %0d exp=10 3f80 1", out_valid, in_ready, out_data, out_count);
            end
        end
        consume();
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL release_idle got=%b%b exp=01", out_valid, in_ready);
        end
    endtask

    task automatic test_two();
        send(16'h3F80, 1'b0);
        send(16'h4000, 1'b1);
        total++;
        if ({add_a, add_b} !== {16'h3F80, 16'h4000}) begin
            bad++; $display("FAIL two_operands got=%h %h exp=3f80 4000", add_a, add_b);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({in_ready, out_valid} !== 2'b00) begin
                bad++; $display("FAIL two_wait%0d got=%b%b exp=00", i, in_ready, out_valid);
            end
        end
        @(negedge clk);
        total++;
        if ({out_valid, out_data, out_count} !== {1'b1, 16'h4040, 8'd2}) begin
            bad++; $display("FAIL two_sum got=%b %h %0d exp=1 4040 2", out_valid, out_data, out_count);
        end
        consume();
    endtask

    task automatic test_three();
        send(16'h3F80, 1'b0);
        send(16'h3F80, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL three_wait_a%0d got=%b exp=0", i, in_ready); end
        end
        send(16'h4000, 1'b1);
        total++;
        if ({add_a, add_b} !== {16'h4000, 16'h4000}) begin
            bad++; $display("FAIL three_operands got=%h %h exp=4000 4000", add_a, add_b);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({in_ready, out_valid} !== 2'b00) begin bad++; $display("FAIL three_wait_b%0d got=%b%b exp=00", i, in_ready, out_valid); end
        end
        @(negedge clk);
        total++;
        if ({out_valid, out_data, out_count} !== {1'b1, 16'h4080, 8'd3}) begin
            bad++; $display("FAIL three_sum got=%b %h %0d exp=1 4080 3", out_valid, out_data, out_count);
        end
        consume();
    endtask

    task automatic test_hold_valid();
        int accepts = 0;
        int n = 0;
        in_valid = 1'b1; in_data = 16'h4000;
        while (n < 100) begin
            @(negedge clk);
            if (out_valid) break;
            in_last = (accepts == 2);
            if (in_ready) accepts++;
            n++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        total++;
        if ({out_valid, out_data, out_count} !== {1'b1, 16'h40C0, 8'd3} || accepts != 3) begin
            bad++; $display("FAIL hold_valid got=%b %h %0d acc=%0d exp=1 40c0 3 acc=3", out_valid, out_data, out_count, accepts);
        end
        consume();
    endtask

    task automatic test_saturate();
        int n = 0;
        for (int i = 0; i < 299; i++) send(16'h0000, 1'b0);
        send(16'h3F80, 1'b1);
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        total++;
        if ({out_valid, out_data, out_count} !== {1'b1, 16'h3F80, 8'd255}) begin
            bad++; $display("FAIL saturate got=%b %h %0d exp=1 3f80 255", out_valid, out_data, out_count);
        end
        consume();
    endtask

    task automatic test_reset_mid_wait();
        int n = 0;
        send(16'h3F80, 1'b0);
        send(16'h4000, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, add_a, add_b, out_data, out_count} !== {1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 8'h0}) begin
            bad++;
            $display("FAIL reset_mid_wait got=%b%b %h %h %h %h exp=10 0 0 0 0", in_ready, out_valid, add_a, add_b, out_data, out_count);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_no_pulse%0d got=%b exp=0", i, out_valid); end
        end
        rst_n = 1'b1;
        send(16'h4040, 1'b1);
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        total++;
        if ({out_valid, out_data, out_count} !== {1'b1, 16'h4040, 8'd1}) begin
            bad++; $display("FAIL after_reset got=%b %h %0d exp=1 4040 1", out_valid, out_data, out_count);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_single_backpressure();
        test_two();
        test_three();
        test_hold_valid();
        test_saturate();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
